// File: rtl/control_unit_if.sv
// Bus between the control_unit and the accumulator datapath: instruction fetch,
// data memory handshake, datapath strobes and the flags register.
interface control_unit_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_ack;
  logic              mdr_wr;
  logic [ADDR_W-1:0] operand;
  logic              acc_wr;
  logic [1:0]        acc_src;
  logic              alu_op;
  logic              alu_b_src;
  logic              flags_wr;
  logic              flags_reset;
  logic              flag_Z;
  logic              flag_N;
  logic              halted;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, mdr_wr, operand,
           acc_wr, acc_src, alu_op, alu_b_src, flags_wr, flags_reset, halted,
    input  imem_ack, imem_data, dmem_ack, flag_Z, flag_N
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, mdr_wr, operand,
           acc_wr, acc_src, alu_op, alu_b_src, flags_wr, flags_reset, halted,
    output imem_ack, imem_data, dmem_ack, flag_Z, flag_N
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle controller for the accumulator datapath: owns PC and IR, fetches,
// decodes and sequences memory, ALU, accumulator and flags.
module control_unit #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input logic            clock,
  input logic            control_reset,
  control_unit_if.master bus
);
  typedef enum logic [2:0] {INIT, FETCH, DECODE, MEM, EXEC, HALT} state_t;

  typedef enum logic [4:0] {
    OP_HLT  = 5'h00, OP_STO  = 5'h01, OP_LD   = 5'h02, OP_LDI  = 5'h03,
    OP_ADD  = 5'h04, OP_ADDI = 5'h05, OP_SUB  = 5'h06, OP_SUBI = 5'h07,
    OP_BEQ  = 5'h08, OP_BNE  = 5'h09, OP_BGT  = 5'h0A, OP_BGE  = 5'h0B,
    OP_BLT  = 5'h0C, OP_BLE  = 5'h0D, OP_JMP  = 5'h0E, OP_NOP  = 5'h0F
  } op_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  op_t               op;

  logic       is_sto, is_halt, needs_mem, has_exec, take;
  logic       x_acc_wr, x_alu_op, x_alu_b_src, x_flags_wr;
  logic [1:0] x_acc_src;

  logic       imem_req_q, dmem_req_q, dmem_we_q, acc_wr_q, alu_op_q;
  logic       alu_b_src_q, flags_wr_q, flags_reset_q, halted_q;
  logic [1:0] acc_src_q;

  assign op      = op_t'(ir[DATA_W-1:ADDR_W]);
  assign is_sto  = (op == OP_STO);
  assign is_halt = (op == OP_HLT);

  // Instruction class, EXEC strobe set and branch decision, all from IR and flags.
  always_comb begin
    needs_mem   = 1'b0;
    has_exec    = 1'b0;
    take        = 1'b0;
    x_acc_wr    = 1'b0;
    x_acc_src   = '0;
    x_alu_op    = 1'b0;
    x_alu_b_src = 1'b0;
    x_flags_wr  = 1'b0;
    case (op)
      OP_STO: needs_mem = 1'b1;
      OP_LD: begin
        needs_mem  = 1'b1;
        x_acc_wr   = 1'b1;
        x_acc_src  = 2'b10;
        x_flags_wr = 1'b1;
      end
      OP_LDI: begin
        has_exec   = 1'b1;
        x_acc_wr   = 1'b1;
        x_acc_src  = 2'b01;
        x_flags_wr = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        needs_mem   = 1'b1;
        x_acc_wr    = 1'b1;
        x_alu_op    = (op == OP_SUB);
        x_alu_b_src = 1'b1;
        x_flags_wr  = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        has_exec   = 1'b1;
        x_acc_wr   = 1'b1;
        x_alu_op   = (op == OP_SUBI);
        x_flags_wr = 1'b1;
      end
      OP_BEQ: begin has_exec = 1'b1; take = bus.flag_Z; end
      OP_BNE: begin has_exec = 1'b1; take = !bus.flag_Z; end
      OP_BGT: begin has_exec = 1'b1; take = !bus.flag_Z && !bus.flag_N; end
      OP_BGE: begin has_exec = 1'b1; take = !bus.flag_N; end
      OP_BLT: begin has_exec = 1'b1; take = bus.flag_N; end
      OP_BLE: begin has_exec = 1'b1; take = bus.flag_N || bus.flag_Z; end
      OP_JMP: begin has_exec = 1'b1; take = 1'b1; end
      default: ;
    endcase
  end

  // Strobes are registered: each transition loads the strobe set of the state being entered.
  always_ff @(posedge clock or negedge control_reset) begin
    if (!control_reset) begin
      state         <= INIT;
      pc            <= '0;
      ir            <= '0;
      imem_req_q    <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      acc_wr_q      <= 1'b0;
      acc_src_q     <= '0;
      alu_op_q      <= 1'b0;
      alu_b_src_q   <= 1'b0;
      flags_wr_q    <= 1'b0;
      flags_reset_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      imem_req_q    <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      acc_wr_q      <= 1'b0;
      acc_src_q     <= '0;
      alu_op_q      <= 1'b0;
      alu_b_src_q   <= 1'b0;
      flags_wr_q    <= 1'b0;
      flags_reset_q <= 1'b0;
      case (state)
        INIT: begin
          // INIT spans the reset-exit cycle (flags_reset low) and one pulse cycle.
          if (!flags_reset_q) begin
            flags_reset_q <= 1'b1;
          end else begin
            state      <= FETCH;
            imem_req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.imem_ack) begin
            ir    <= bus.imem_data;
            pc    <= pc + ADDR_W'(1);
            state <= DECODE;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        DECODE: begin
          if (is_halt) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else if (needs_mem) begin
            state      <= MEM;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_sto;
          end else if (has_exec) begin
            state       <= EXEC;
            acc_wr_q    <= x_acc_wr;
            acc_src_q   <= x_acc_src;
            alu_op_q    <= x_alu_op;
            alu_b_src_q <= x_alu_b_src;
            flags_wr_q  <= x_flags_wr;
          end else begin
            state      <= FETCH;
            imem_req_q <= 1'b1;
          end
        end
        MEM: begin
          if (!bus.dmem_ack) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_sto;
          end else if (is_sto) begin
            state      <= FETCH;
            imem_req_q <= 1'b1;
          end else begin
            state       <= EXEC;
            acc_wr_q    <= x_acc_wr;
            acc_src_q   <= x_acc_src;
            alu_op_q    <= x_alu_op;
            alu_b_src_q <= x_alu_b_src;
            flags_wr_q  <= x_flags_wr;
          end
        end
        EXEC: begin
          if (take) pc <= ir[ADDR_W-1:0];
          state      <= FETCH;
          imem_req_q <= 1'b1;
        end
        HALT: ;
        default: state <= INIT;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc;
  assign bus.dmem_req    = dmem_req_q;
  assign bus.dmem_we     = dmem_we_q;
  assign bus.dmem_addr   = ir[ADDR_W-1:0];
  assign bus.operand     = ir[ADDR_W-1:0];
  assign bus.mdr_wr      = (state == MEM) && bus.dmem_ack && !is_sto;
  assign bus.acc_wr      = acc_wr_q;
  assign bus.acc_src     = acc_src_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_b_src   = alu_b_src_q;
  assign bus.flags_wr    = flags_wr_q;
  assign bus.flags_reset = flags_reset_q;
  assign bus.halted      = halted_q;
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: programs push expected events, a negedge
// monitor pops and compares every fetch, memory, exec, flags-reset and halt event.
module tb_control_unit;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {EV_FRST, EV_FETCH, EV_MEM, EV_EXEC, EV_HALT, EV_MDR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] val;
    int          cyc;
  } ev_t;
  typedef struct {
    logic [4:0] op;
    logic       z;
    logic       n;
    logic       taken;
  } br_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic fz = 1'b0;
  logic fn = 1'b0;
  int   ddelay = 0;
  int   dcnt;
  int   cyc;
  int   req_len = 0;
  logic halted_q = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [DW-1:0] prog [0:(1<<AW)-1];

  control_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  control_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .control_reset(rst_n),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  assign bus.imem_ack  = 1'b1;
  assign bus.imem_data = prog[bus.imem_addr];
  assign bus.dmem_ack  = bus.dmem_req && (dcnt == ddelay);
  assign bus.flag_Z    = fz;
  assign bus.flag_N    = fn;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= 0;
      cyc  <= 0;
    end else begin
      cyc  <= cyc + 1;
      dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
    end
  end

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] a);
    return {op, a};
  endfunction

  function automatic logic [31:0] mem_val(input logic [3:0] len, input logic we,
                                          input logic mdr, input logic [10:0] a);
    return 32'({len, we, mdr, a});
  endfunction

  task automatic expect_ev(input ev_kind_t k, input logic [31:0] v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_kind_t k, input logic [31:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got val=%h at cycle %0d, required no event", k.name(), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || (e.cyc >= 0 && e.cyc != cyc)) begin
        errors++;
        $display("FAIL %s: got %s val=%h cyc=%0d, required %s val=%h cyc=%0d",
                 e.kind.name(), k.name(), v, cyc, e.kind.name(), e.val, e.cyc);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (!rst_n) begin
      req_len  = 0;
      halted_q = 1'b0;
    end else begin
      req_len = bus.dmem_req ? req_len + 1 : 0;
      if (bus.flags_reset) got(EV_FRST, 32'd0);
      if (bus.imem_req && bus.imem_ack) got(EV_FETCH, 32'(bus.imem_addr));
      if (bus.dmem_req && bus.dmem_ack)
        got(EV_MEM, mem_val(4'(req_len), bus.dmem_we, bus.mdr_wr, bus.dmem_addr));
      if (bus.mdr_wr && !(bus.dmem_req && bus.dmem_ack)) got(EV_MDR, 32'd0);
      if (bus.acc_wr || bus.flags_wr || bus.alu_op || bus.alu_b_src || bus.acc_src != 2'b00)
        got(EV_EXEC, 32'({bus.acc_wr, bus.acc_src, bus.alu_op, bus.alu_b_src, bus.flags_wr}));
      if (bus.halted && !halted_q) got(EV_HALT, 32'(bus.imem_addr));
      halted_q = bus.halted;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.mdr_wr,
                                  bus.acc_wr, bus.acc_src, bus.alu_op, bus.alu_b_src,
                                  bus.flags_wr, bus.flags_reset, bus.halted}), 32'd0);
    check({tag, "_addrs"}, 32'({bus.imem_addr, bus.dmem_addr, bus.operand}), 32'd0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < (1 << AW); i++) prog[i] = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!bus.halted && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_halted"}, 32'(bus.halted), 32'd1);
    @(negedge clock);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  br_t br_tab[8] = '{
    '{5'h08, 1'b1, 1'b0, 1'b1},
    '{5'h09, 1'b1, 1'b0, 1'b0},
    '{5'h0C, 1'b0, 1'b1, 1'b1},
    '{5'h0D, 1'b0, 1'b1, 1'b1},
    '{5'h0B, 1'b0, 1'b1, 1'b0},
    '{5'h0A, 1'b0, 1'b0, 1'b1},
    '{5'h0A, 1'b1, 1'b0, 1'b0},
    '{5'h0E, 1'b1, 1'b1, 1'b1}
  };

  initial begin
    // LDI 5; HLT
    clear_prog();
    prog[0] = ins(5'h03, 11'd5);
    expect_ev(EV_FRST, 0, 1);
    expect_ev(EV_FETCH, 0, 2);
    expect_ev(EV_EXEC, 32'b101001, 4);
    expect_ev(EV_FETCH, 1, 5);
    expect_ev(EV_HALT, 2, 7);
    do_reset("ldi_rst");
    wait_halt("ldi", 50);

    // ADD 0x010 with three wait cycles
    clear_prog();
    prog[0] = ins(5'h04, 11'h010);
    ddelay  = 3;
    expect_ev(EV_FRST, 0, 1);
    expect_ev(EV_FETCH, 0, 2);
    expect_ev(EV_MEM, mem_val(4'd4, 1'b0, 1'b1, 11'h010), 7);
    expect_ev(EV_EXEC, 32'b100011, 8);
    expect_ev(EV_FETCH, 1, 9);
    expect_ev(EV_HALT, 2, 11);
    do_reset("add_rst");
    wait_halt("add", 50);

    // STO 0x7FF
    clear_prog();
    prog[0] = ins(5'h01, 11'h7FF);
    ddelay  = 0;
    expect_ev(EV_FRST, 0, 1);
    expect_ev(EV_FETCH, 0, 2);
    expect_ev(EV_MEM, mem_val(4'd1, 1'b1, 1'b0, 11'h7FF), 4);
    expect_ev(EV_FETCH, 1, 5);
    expect_ev(EV_HALT, 2, 7);
    do_reset("sto_rst");
    wait_halt("sto", 50);

    // Branch at PC=3 to 0x100 under the table's flag settings
    for (int i = 0; i < 8; i++) begin
      int tgt;
      clear_prog();
      for (int j = 0; j < 3; j++) prog[j] = ins(5'h0F, 11'd0);
      prog[3] = ins(br_tab[i].op, 11'h100);
      fz  = br_tab[i].z;
      fn  = br_tab[i].n;
      tgt = br_tab[i].taken ? 32'h100 : 32'd4;
      expect_ev(EV_FRST, 0, 1);
      expect_ev(EV_FETCH, 0, 2);
      expect_ev(EV_FETCH, 1, 4);
      expect_ev(EV_FETCH, 2, 6);
      expect_ev(EV_FETCH, 3, 8);
      expect_ev(EV_FETCH, 32'(tgt), 11);
      expect_ev(EV_HALT, 32'(tgt + 1), 13);
      do_reset("br_rst");
      wait_halt("br", 60);
    end
    fz = 1'b0;
    fn = 1'b0;

    // JMP 0x7FE; 0x1F at 0x7FE; NOP at 0x7FF wraps to 0, which then holds HLT
    clear_prog();
    prog[0]     = ins(5'h0E, 11'h7FE);
    prog[11'h7FE] = ins(5'h1F, 11'd0);
    prog[11'h7FF] = ins(5'h0F, 11'd0);
    expect_ev(EV_FRST, 0, 1);
    expect_ev(EV_FETCH, 0, 2);
    expect_ev(EV_FETCH, 32'h7FE, 5);
    expect_ev(EV_FETCH, 32'h7FF, 7);
    expect_ev(EV_FETCH, 0, 9);
    expect_ev(EV_HALT, 1, 11);
    do_reset("wrap_rst");
    repeat (3) @(negedge clock);
    prog[0] = ins(5'h00, 11'd0);
    wait_halt("wrap", 60);

    // Reset asserted while LD 0x020 waits in MEM
    clear_prog();
    prog[0] = ins(5'h02, 11'h020);
    ddelay  = 20;
    expect_ev(EV_FRST, 0, 1);
    expect_ev(EV_FETCH, 0, 2);
    do_reset("mid_rst0");
    repeat (5) @(negedge clock);
    check("mid_req_before", 32'(bus.dmem_req), 32'd1);
    check("mid_pc_before", 32'(bus.imem_addr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    check("mid_queue", exp_q.size(), 32'd0);
    ddelay = 0;
    expect_ev(EV_FRST, 0, 1);
    expect_ev(EV_FETCH, 0, 2);
    expect_ev(EV_MEM, mem_val(4'd1, 1'b0, 1'b1, 11'h020), 4);
    expect_ev(EV_EXEC, 32'b110001, 5);
    expect_ev(EV_FETCH, 1, 6);
    expect_ev(EV_HALT, 2, 8);
    @(negedge clock);
    rst_n = 1'b1;
    wait_halt("mid", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
